// File: rtl/rx_alu_frame_assembler.sv
// rx_alu_frame_assembler
// Assembles {operand A, operand B, opcode} from consecutive UART bytes and
// commits the whole frame atomically, presenting it with a valid/ack handshake.
// Optional feature: define RX_ALU_TIMEOUT_EN to discard partial frames after
// TIMEOUT_CYCLES idle cycles and pulse o_error.
module rx_alu_frame_assembler #(
    parameter int NB_DATA        = 8,
    parameter int NB_OP_BYTES    = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic [NB_DATA-1:0]             i_rx_data,
    input  logic                           i_rx_done,
    input  logic                           i_ack,
    output logic [NB_DATA*NB_OP_BYTES-1:0] o_operandoA,
    output logic [NB_DATA*NB_OP_BYTES-1:0] o_operandoB,
    output logic [NB_DATA-1:0]             o_opcode,
    output logic                           o_valid,
    output logic                           o_busy,
    output logic                           o_overrun,
    output logic                           o_error
);

    localparam int NB_OPND = NB_DATA * NB_OP_BYTES;
    localparam int CNT_W   = (NB_OP_BYTES > 1) ? $clog2(NB_OP_BYTES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NB_OP_BYTES - 1);

    if (NB_OP_BYTES < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("rx_alu_frame_assembler: NB_OP_BYTES must be >= 1 and TIMEOUT_CYCLES >= 2");
    end

    typedef enum logic [1:0] {
        S_A,
        S_B,
        S_OP,
        S_HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NB_OPND-1:0] shadow_a_q, shadow_a_d;
    logic [NB_OPND-1:0] shadow_b_q, shadow_b_d;
    logic [NB_OPND-1:0] opnd_a_q, opnd_a_d;
    logic [NB_OPND-1:0] opnd_b_q, opnd_b_d;
    logic [NB_DATA-1:0] opcode_q, opcode_d;
    logic               valid_q, valid_d;
    logic               overrun_q, overrun_d;
    logic               busy;
    logic               timeout_hit;

    assign busy = (state_q == S_B) || (state_q == S_OP) ||
                  ((state_q == S_A) && (cnt_q != '0));

`ifdef RX_ALU_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_q;
    logic             error_q;

    // Expiry needs an idle cycle: a strobe on the last cycle keeps the frame alive.
    assign timeout_hit = busy && !i_rx_done && (tmo_q == TMO_LAST);

    // Idle-cycle counter for partial frames and the one-cycle error pulse.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            tmo_q   <= '0;
            error_q <= 1'b0;
        end else begin
            error_q <= timeout_hit;
            if (!busy || i_rx_done || timeout_hit)
                tmo_q <= '0;
            else
                tmo_q <= tmo_q + TMO_W'(1);
        end
    end

    assign o_error = error_q;
`else
    assign timeout_hit = 1'b0;
    assign o_error     = 1'b0;
`endif

    // Next-state logic: byte capture, commit and handshake.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shadow_a_d = shadow_a_q;
        shadow_b_d = shadow_b_q;
        opnd_a_d   = opnd_a_q;
        opnd_b_d   = opnd_b_q;
        opcode_d   = opcode_q;
        valid_d    = valid_q;
        overrun_d  = overrun_q;

        unique case (state_q)
            S_A: begin
                if (i_rx_done) begin
                    shadow_a_d[int'(cnt_q)*NB_DATA +: NB_DATA] = i_rx_data;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = S_B;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_B: begin
                if (i_rx_done) begin
                    shadow_b_d[int'(cnt_q)*NB_DATA +: NB_DATA] = i_rx_data;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = S_OP;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_OP: begin
                if (i_rx_done) begin
                    opnd_a_d = shadow_a_q;
                    opnd_b_d = shadow_b_q;
                    opcode_d = i_rx_data;
                    valid_d  = 1'b1;
                    state_d  = S_HOLD;
                end
            end
            S_HOLD: begin
                if (i_ack) begin
                    valid_d = 1'b0;
                    state_d = S_A;
                    cnt_d   = '0;
                    if (i_rx_done) begin
                        // Byte arriving with the ack is slot 0 of the next A.
                        shadow_a_d[NB_DATA-1:0] = i_rx_data;
                        if (CNT_LAST == '0) begin
                            state_d = S_B;
                        end else begin
                            cnt_d = CNT_W'(1);
                        end
                    end
                end else if (i_rx_done) begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = S_A;
        endcase

        if (timeout_hit) begin
            state_d = S_A;
            cnt_d   = '0;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q    <= S_A;
            cnt_q      <= '0;
            shadow_a_q <= '0;
            shadow_b_q <= '0;
            opnd_a_q   <= '0;
            opnd_b_q   <= '0;
            opcode_q   <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shadow_a_q <= shadow_a_d;
            shadow_b_q <= shadow_b_d;
            opnd_a_q   <= opnd_a_d;
            opnd_b_q   <= opnd_b_d;
            opcode_q   <= opcode_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign o_operandoA = opnd_a_q;
    assign o_operandoB = opnd_b_q;
    assign o_opcode    = opcode_q;
    assign o_valid     = valid_q;
    assign o_busy      = busy;
    assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_rx_alu_frame_assembler.sv
// Testbench for rx_alu_frame_assembler: directed byte sequences, a frame-level
// reference model compared every cycle, plus literal expectations.
module tb_rx_alu_frame_assembler;

    localparam int NB  = 2;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        i_reset = 1'b0;
    logic [7:0]  i_rx_data = '0;
    logic        i_rx_done = 1'b0;
    logic        i_ack = 1'b0;
    logic [15:0] o_operandoA, o_operandoB;
    logic [7:0]  o_opcode;
    logic        o_valid, o_busy, o_overrun, o_error;

    rx_alu_frame_assembler #(
        .NB_DATA        (8),
        .NB_OP_BYTES    (NB),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_rx_data   (i_rx_data),
        .i_rx_done   (i_rx_done),
        .i_ack       (i_ack),
        .o_operandoA (o_operandoA),
        .o_operandoB (o_operandoB),
        .o_opcode    (o_opcode),
        .o_valid     (o_valid),
        .o_busy      (o_busy),
        .o_overrun   (o_overrun),
        .o_error     (o_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic cmp_en = 1'b0;

    // Frame-level model: bytes collected so far plus the committed frame.
    logic [7:0]  frame[$];
    logic [15:0] m_a = '0, m_b = '0;
    logic [7:0]  m_op = '0;
    logic        m_valid = 1'b0, m_overrun = 1'b0, m_error = 1'b0;
    int          idle = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic rst_n, input logic done, input logic [7:0] data, input logic ack);
        if (!rst_n) begin
            frame.delete();
            m_a = '0; m_b = '0; m_op = '0;
            m_valid = 0; m_overrun = 0; m_error = 0; idle = 0;
        end else begin
            m_error = 0;
            if (m_valid) begin
                if (ack) begin
                    m_valid = 0;
                    if (done) frame.push_back(data);
                end else if (done) begin
                    m_overrun = 1;
                end
                idle = 0;
            end else if (done) begin
                frame.push_back(data);
                idle = 0;
                if (frame.size() == 2*NB+1) begin
                    for (int i = 0; i < NB; i++) begin
                        m_a[i*8 +: 8] = frame[i];
                        m_b[i*8 +: 8] = frame[NB+i];
                    end
                    m_op = frame[2*NB];
                    m_valid = 1;
                    frame.delete();
                end
            end else if (frame.size() != 0) begin
`ifdef RX_ALU_TIMEOUT_EN
                idle++;
                if (idle == TMO) begin
                    frame.delete();
                    idle = 0;
                    m_error = 1;
                end
`endif
            end
        end
    endtask

    // One clock cycle: drive inputs, advance the model on the edge, settle.
    task automatic step(input logic done, input logic [7:0] data, input logic ack, input logic rst_n = 1'b1);
        i_rx_done = done;
        i_rx_data = data;
        i_ack     = ack;
        i_reset   = rst_n;
        @(posedge clk);
        model_edge(rst_n, done, data, ack);
        #1;
        i_rx_done = 1'b0;
        i_ack     = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        step(1'b1, b, 1'b0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
    endtask

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_A",       o_operandoA, m_a);
            check("model_B",       o_operandoB, m_b);
            check("model_opcode",  o_opcode,    m_op);
            check("model_valid",   o_valid,     m_valid);
            check("model_busy",    o_busy,      frame.size() != 0);
            check("model_overrun", o_overrun,   m_overrun);
            check("model_error",   o_error,     m_error);
        end
    end

    initial begin
        repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0);
        cmp_en = 1'b1;
        check("rst_A", o_operandoA, 16'h0000);
        check("rst_valid", o_valid, 1'b0);
        check("rst_busy", o_busy, 1'b0);
        check("rst_overrun", o_overrun, 1'b0);
        idle_cycles(2);

        // Basic frame with gaps between strobes.
        send(8'h34); idle_cycles(1); send(8'h12); send(8'h78); idle_cycles(2);
        send(8'h56);
        check("mid_valid", o_valid, 1'b0);
        check("mid_busy", o_busy, 1'b1);
        send(8'h20);
        check("f1_A", o_operandoA, 16'h1234);
        check("f1_B", o_operandoB, 16'h5678);
        check("f1_op", o_opcode, 8'h20);
        check("f1_valid", o_valid, 1'b1);
        check("f1_busy", o_busy, 1'b0);

        // Byte during hold without ack is dropped.
        send(8'hFF);
        check("ovr_flag", o_overrun, 1'b1);
        check("ovr_A_held", o_operandoA, 16'h1234);
        check("ovr_op_held", o_opcode, 8'h20);
        step(1'b0, 8'h00, 1'b1);
        check("ack_valid", o_valid, 1'b0);
        check("ack_busy", o_busy, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        check("ack_hold_overrun", o_overrun, 1'b1);

        // Back-to-back strobes.
        for (int i = 1; i <= 4; i++) send(8'(i));
        check("b2b_not_early", o_valid, 1'b0);
        send(8'h05);
        check("b2b_A", o_operandoA, 16'h0201);
        check("b2b_B", o_operandoB, 16'h0403);
        check("b2b_op", o_opcode, 8'h05);
        check("b2b_valid", o_valid, 1'b1);

        // Ack coinciding with the first byte of the next frame.
        step(1'b1, 8'hAA, 1'b1);
        check("ackbyte_valid", o_valid, 1'b0);
        check("ackbyte_busy", o_busy, 1'b1);
        check("ackbyte_A_held", o_operandoA, 16'h0201);
        send(8'hBB); send(8'h01); send(8'h00); send(8'h02);
        check("f3_A", o_operandoA, 16'hBBAA);
        check("f3_B", o_operandoB, 16'h0001);
        check("f3_op", o_opcode, 8'h02);
        check("f3_valid", o_valid, 1'b1);

        // Reset in the middle of a frame.
        step(1'b0, 8'h00, 1'b1);
        send(8'h11); send(8'h22); send(8'h33);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("mrst_A", o_operandoA, 16'h0000);
        check("mrst_B", o_operandoB, 16'h0000);
        check("mrst_op", o_opcode, 8'h00);
        check("mrst_busy", o_busy, 1'b0);
        check("mrst_overrun", o_overrun, 1'b0);
        send(8'h01); send(8'h00); send(8'h02); send(8'h00); send(8'h08);
        check("f4_A", o_operandoA, 16'h0001);
        check("f4_B", o_operandoB, 16'h0002);
        check("f4_op", o_opcode, 8'h08);
        step(1'b0, 8'h00, 1'b1);

`ifdef RX_ALU_TIMEOUT_EN
        // Partial frame abandoned after TMO idle cycles.
        send(8'h11); send(8'h22);
        idle_cycles(TMO - 1);
        check("tmo_not_yet", o_error, 1'b0);
        idle_cycles(1);
        check("tmo_error", o_error, 1'b1);
        check("tmo_busy", o_busy, 1'b0);
        check("tmo_A_held", o_operandoA, 16'h0001);
        check("tmo_valid", o_valid, 1'b0);
        idle_cycles(1);
        check("tmo_pulse_end", o_error, 1'b0);
        // Strobe on the expiring cycle keeps the frame alive.
        send(8'h66); send(8'h77);
        idle_cycles(TMO - 1);
        send(8'h88);
        check("tmo_race_error", o_error, 1'b0);
        check("tmo_race_busy", o_busy, 1'b1);
        send(8'h99); send(8'hAA);
        check("tmo_f_A", o_operandoA, 16'h7766);
        check("tmo_f_B", o_operandoB, 16'h9988);
        check("tmo_f_op", o_opcode, 8'hAA);
        check("tmo_f_valid", o_valid, 1'b1);
`else
        // Without the timeout a partial frame waits indefinitely.
        send(8'h11); send(8'h22);
        idle_cycles(TMO + 4);
        check("wait_busy", o_busy, 1'b1);
        check("wait_error", o_error, 1'b0);
        send(8'h33); send(8'h44); send(8'h55);
        check("wait_A", o_operandoA, 16'h2211);
        check("wait_B", o_operandoB, 16'h4433);
        check("wait_op", o_opcode, 8'h55);
        check("wait_valid", o_valid, 1'b1);
`endif
        idle_cycles(2);
        cmp_en = 1'b0;
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_alu_frame_assembler.md
# rx_alu_frame_assembler

Parametrised successor to the three-latch RX capture stage feeding the ALU. It sits between the UART receiver and the ALU. It assembles a frame from consecutive received bytes: operand A (multi-byte), then operand B (multi-byte), then the opcode (one byte). A control FSM sequences the capture, and a commit stage updates all three outputs atomically. A valid/ack handshake presents the frame to the consumer.

## Interface
- NB_DATA, 8, UART byte width; opcode width.
- NB_OP_BYTES, 2, bytes per operand (≥1); operand width = NB_DATA*NB_OP_BYTES.
- TIMEOUT_CYCLES, 50000, inter-byte timeout in clock cycles (≥2); used only with the timeout macro.

Ports:
- i_clk  in  1  single clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-low reset.
- i_rx_data  in  NB_DATA  received byte; sampled only when i_rx_done=1.
- i_rx_done  in  1  one-cycle byte strobe from the UART receiver.
- i_ack  in  1  consumer accepts the presented frame; ignored while o_valid=0.
- o_operandoA  out  NB_DATA*NB_OP_BYTES  committed operand A.
- o_operandoB  out  NB_DATA*NB_OP_BYTES  committed operand B.
- o_opcode  out  NB_DATA  committed opcode.
- o_valid  out  1  a committed frame is awaiting i_ack.
- o_busy  out  1  a partial frame is in progress.
- o_overrun  out  1  sticky; set when a byte is dropped in S_HOLD.
- o_error  out  1  one-cycle timeout pulse; constant 0 without the macro.

## Operation
- States: S_A, S_B, S_OP, S_HOLD. Byte counter width is clog2(NB_OP_BYTES), minimum 1.
- S_A / S_B:
  - On i_rx_done, the byte goes into the shadow A/B register at byte slot cnt. Ordering is little-endian: the first byte lands in [NB_DATA-1:0].
  - cnt increments on each byte. On the byte where cnt==NB_OP_BYTES-1, cnt returns to 0 and the FSM advances (S_A→S_B, S_B→S_OP).
- S_OP:
  - On i_rx_done, the byte is the opcode.
  - On that same edge, the shadow A, shadow B and opcode byte are copied to the outputs, o_valid goes to 1, and the FSM moves to S_HOLD.
- S_HOLD:
  - Outputs are frozen.
  - i_ack=1 clears o_valid and moves the FSM to S_A with cnt=0.
  - i_rx_done without i_ack: the byte is discarded and o_overrun is set.
  - i_rx_done together with i_ack: the byte is accepted as A slot 0, the FSM goes to S_A, cnt=1, and o_overrun is unchanged.
- Outputs hold the last committed frame while the next frame is assembled. Partial frames never reach the outputs.
- o_busy = 1 when the FSM is in S_B or S_OP, or in S_A with cnt≠0.
- Reset (any cycle, including mid-frame or during S_HOLD):
  - State S_A, cnt=0.
  - Shadow registers and all outputs 0; o_valid, o_busy, o_overrun, o_error all 0.

## Timing
- Byte capture takes effect on the edge where i_rx_done=1. Strobes on every consecutive cycle are supported with no gap required.
- Commit latency: outputs and o_valid change on the edge sampling the opcode strobe, so they are visible the following cycle.
- An i_ack sampled high with o_valid=1 drops o_valid on that edge. An i_ack held high for several cycles has no further effect.
- o_overrun is set on the edge sampling the dropped byte and is cleared only by reset.
- Frame length is 2*NB_OP_BYTES+1 strobes. The minimum frame-to-frame period is that many cycles plus one ack cycle, or zero extra cycles when ack coincides with the next byte.

## Configuration
- RX_ALU_TIMEOUT_EN defined:
  - A counter runs while o_busy=1 and resets to 0 on every accepted byte.
  - After TIMEOUT_CYCLES consecutive cycles with no strobe, the partial frame is discarded: state S_A, cnt=0, o_busy=0.
  - o_error pulses high for exactly one cycle. Committed outputs and o_valid are untouched.
  - A strobe arriving on the expiring cycle wins: the byte is accepted, the counter is cleared, and there is no error.
- RX_ALU_TIMEOUT_EN undefined:
  - No counter is instantiated and o_error is tied 0.
  - A partial frame waits indefinitely.

## Test plan
- NB_DATA=8, NB_OP_BYTES=2: strobe 0x34,0x12,0x78,0x56,0x20 → the cycle after the fifth strobe shows o_operandoA=0x1234, o_operandoB=0x5678, o_opcode=0x20, o_valid=1, o_busy=0.
- Frame committed, o_valid=1; strobe 0xFF without ack → outputs unchanged, o_overrun=1; then i_ack=1 → o_valid=0 next cycle, FSM in S_A.
- Frame committed; i_ack=1 and strobe 0xAA on the same cycle → o_valid=0, o_busy=1. Then strobe 0xBB,0x01,0x00,0x02 → o_operandoA=0xBBAA, o_operandoB=0x0001, o_opcode=0x02, o_valid=1.
- Reset asserted after 3 strobes of a frame → all outputs 0 on the next cycle. A following full frame 0x01,0x00,0x02,0x00,0x08 yields A=0x0001, B=0x0002, opcode=0x08.
- Macro on, TIMEOUT_CYCLES=16: strobe 2 bytes, then 16 idle cycles → one-cycle o_error, o_busy=0, previous committed values retained. The next 5-byte frame commits correctly.
- Five strobes on consecutive cycles (0x01..0x05) → A=0x0201, B=0x0403, opcode=0x05, o_valid=1 exactly one cycle after the last strobe.
